// File: rtl/load_store_initiator.sv
// load_store_initiator: turns one load/store request into a single byte-lane
// bus transaction, waits for the responder, then returns extended load data
// with a one-cycle completion pulse. Misaligned or illegal requests and bus
// timeouts complete with an error flag.
module load_store_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        request,
  input  logic        write_enable,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        access_done,
  output logic        access_error,
  output logic        busy,
  output logic        mem_enable,
  output logic        mem_state,
  output logic [3:0]  frame_mask,
  output logic [31:0] mem_address,
  inout  wire  [31:0] data,
  input  logic        memory_done
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_write;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_load_data;
  logic              r_access_done;
  logic              r_access_error;
  logic              r_busy;
  logic              r_mem_enable;
  logic              r_mem_state;
  logic [3:0]        r_frame_mask;
  logic [31:0]       r_mem_address;

  logic              w_accept;
  logic              w_reject;
  logic              w_go_access;
  logic              w_timeout;
  logic              w_capture;

  // Width code / alignment legality: loads-only unsigned codes, natural alignment.
  function automatic logic is_rejected(input logic [2:0] f3, input logic we,
                                       input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = (off != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Big-endian lane select: byte offset 0 sits on mask bit 3.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   m = 4'b1000;
          2'b01:   m = 4'b0100;
          2'b10:   m = 4'b0010;
          default: m = 4'b0001;
        endcase
      end
      2'b01:   m = off[1] ? 4'b0011 : 4'b1100;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Right-justified bus data to a 32-bit register value.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b100:  r = {24'h000000, d[7:0]};
      3'b101:  r = {16'h0000, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign w_accept    = (r_state == S_IDLE) && request;
  assign w_reject    = is_rejected(funct3, write_enable, address[1:0]);
  assign w_go_access = (w_next_state == S_ACCESS);
  assign w_timeout   = (r_state == S_ACCESS) && !memory_done && (r_count == CNT_LAST);
  assign w_capture   = (r_state == S_ACCESS) && memory_done && !r_write;

  // Initiator drives the shared bus only while a store is on the bus.
  assign data = r_mem_state ? r_wdata : 32'bz;

  assign load_data    = r_load_data;
  assign access_done  = r_access_done;
  assign access_error = r_access_error;
  assign busy         = r_busy;
  assign mem_enable   = r_mem_enable;
  assign mem_state    = r_mem_state;
  assign frame_mask   = r_frame_mask;
  assign mem_address  = r_mem_address;

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (request) begin
          w_next_state = w_reject ? S_ERROR : S_ACCESS;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (memory_done) begin
          w_next_state = S_RELEASE;
        end else if (r_count == CNT_LAST) begin
          w_next_state = S_RELEASE;
        end else begin
          w_next_state = S_ACCESS;
        end
      end
      S_RELEASE: w_next_state = S_IDLE;
      S_ERROR:   w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request capture at acceptance; fields stay stable for the whole transaction.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_wdata  <= 32'h0000_0000;
    end else if (w_accept) begin
      r_write  <= write_enable;
      r_funct3 <= funct3;
      r_wdata  <= store_data;
    end
  end

  // ACCESS cycle counter for the timeout; cleared whenever ACCESS is not continuing.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if ((r_state == S_ACCESS) && w_go_access) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= {CNT_W{1'b0}};
    end
  end

  // Registered status outputs decoded from the upcoming state.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_access_done  <= 1'b0;
      r_access_error <= 1'b0;
      r_busy         <= 1'b0;
      r_mem_enable   <= 1'b0;
    end else begin
      r_access_done  <= (w_next_state == S_RELEASE) || (w_next_state == S_ERROR);
      r_access_error <= (w_next_state == S_ERROR) || w_timeout;
      r_busy         <= (w_next_state != S_IDLE);
      r_mem_enable   <= w_go_access;
    end
  end

  // Bus command registers: loaded on acceptance, held through ACCESS, lanes dropped after.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_frame_mask  <= 4'b0000;
      r_mem_state   <= 1'b0;
      r_mem_address <= 32'h0000_0000;
    end else if (w_accept && w_go_access) begin
      r_frame_mask  <= lane_mask(funct3[1:0], address[1:0]);
      r_mem_state   <= write_enable;
      r_mem_address <= {address[31:2], 2'b00};
    end else if (!w_go_access) begin
      r_frame_mask  <= 4'b0000;
      r_mem_state   <= 1'b0;
    end
  end

  // Load result: updated only by a load that the responder completed.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_load_data <= 32'h0000_0000;
    end else if (w_capture) begin
      r_load_data <= extend_load(r_funct3, data);
    end
  end

endmodule

// File: tb/tb_load_store_initiator.sv
// Directed bench for load_store_initiator with a big-endian byte memory
// responder whose latency depends on the access width.
module tb_load_store_initiator;

  logic        CLK = 1'b0;
  logic        reset;
  logic        request;
  logic        write_enable;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        access_done;
  logic        access_error;
  logic        busy;
  logic        mem_enable;
  logic        mem_state;
  logic [3:0]  frame_mask;
  logic [31:0] mem_address;
  logic        memory_done;
  wire  [31:0] data_bus;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  load_store_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .reset(reset), .request(request), .write_enable(write_enable),
    .funct3(funct3), .address(address), .store_data(store_data),
    .load_data(load_data), .access_done(access_done), .access_error(access_error),
    .busy(busy), .mem_enable(mem_enable), .mem_state(mem_state),
    .frame_mask(frame_mask), .mem_address(mem_address), .data(data_bus),
    .memory_done(memory_done)
  );

  // Responder: byte memory, big-endian lanes, 3/4/6 enabled cycles for byte/half/word.
  logic [7:0]  mem [0:1023];
  logic [3:0]  resp_cnt;
  logic [3:0]  resp_len;
  logic        resp_hold;
  logic [31:0] resp_rdata;
  logic [9:0]  ra;

  assign ra = mem_address[9:0];

  // Responder latency from the lane count.
  always_comb begin
    resp_len = 4'd3;
    case (frame_mask)
      4'b1111:          resp_len = 4'd6;
      4'b1100, 4'b0011: resp_len = 4'd4;
      default:          resp_len = 4'd3;
    endcase
  end

  // Responder read data, right-justified.
  always_comb begin
    resp_rdata = 32'h0;
    case (frame_mask)
      4'b1000: resp_rdata = {24'h0, mem[ra]};
      4'b0100: resp_rdata = {24'h0, mem[ra + 10'd1]};
      4'b0010: resp_rdata = {24'h0, mem[ra + 10'd2]};
      4'b0001: resp_rdata = {24'h0, mem[ra + 10'd3]};
      4'b1100: resp_rdata = {16'h0, mem[ra], mem[ra + 10'd1]};
      4'b0011: resp_rdata = {16'h0, mem[ra + 10'd2], mem[ra + 10'd3]};
      4'b1111: resp_rdata = {mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3]};
      default: resp_rdata = 32'h0;
    endcase
  end

  assign memory_done = mem_enable && !resp_hold && (resp_cnt == resp_len - 4'd1);
  assign data_bus = (mem_enable && !mem_state && memory_done) ? resp_rdata : 32'bz;

  // Responder cycle count and store write-back.
  always @(posedge CLK) begin
    resp_cnt <= mem_enable ? resp_cnt + 4'd1 : 4'd0;
    if (mem_enable && mem_state && memory_done) begin
      case (frame_mask)
        4'b1000: mem[ra]          <= data_bus[7:0];
        4'b0100: mem[ra + 10'd1]  <= data_bus[7:0];
        4'b0010: mem[ra + 10'd2]  <= data_bus[7:0];
        4'b0001: mem[ra + 10'd3]  <= data_bus[7:0];
        4'b1100: begin mem[ra] <= data_bus[15:8]; mem[ra + 10'd1] <= data_bus[7:0]; end
        4'b0011: begin mem[ra + 10'd2] <= data_bus[15:8]; mem[ra + 10'd3] <= data_bus[7:0]; end
        4'b1111: begin
          mem[ra]         <= data_bus[31:24];
          mem[ra + 10'd1] <= data_bus[23:16];
          mem[ra + 10'd2] <= data_bus[15:8];
          mem[ra + 10'd3] <= data_bus[7:0];
        end
        default: ;
      endcase
    end
  end

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  lat;
    logic        err;
    logic [31:0] ld;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs [0:23];

  function automatic logic bus_idle(input logic [31:0] v);
    return $isunknown(v) || (v == 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, output int lat, output logic err,
                            output logic [31:0] ld, output logic [3:0] mask,
                            output logic [31:0] maddr, output logic mst,
                            output logic [31:0] bus1, output logic rel_idle,
                            output int en_cnt);
    @(posedge CLK); #1;
    write_enable = we; funct3 = f3; address = a; store_data = sd; request = 1'b1;
    @(posedge CLK); #1;
    request = 1'b0;
    lat = -1; en_cnt = 0; err = 1'b0; ld = 32'h0; rel_idle = 1'b0;
    mask = frame_mask; maddr = mem_address; mst = mem_state; bus1 = data_bus;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (mem_enable) en_cnt++;
      if (access_done) begin
        lat = k; err = access_error; ld = load_data; rel_idle = bus_idle(data_bus);
      end else begin
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, {27'h0, access_done, access_error, busy, mem_enable, mem_state}, 32'h0);
    check({tag, " mask"}, {28'h0, frame_mask}, 32'h0);
    check({tag, " addr"}, mem_address, 32'h0);
    check({tag, " load"}, load_data, 32'h0);
    check({tag, " busz"}, {31'h0, bus_idle(data_bus)}, 32'h1);
  endtask

  initial begin
    int          lat, en_cnt;
    logic        err, mst, rel_idle, seen_done;
    logic [31:0] ld, maddr, bus1;
    logic [3:0]  mask;
    logic [9:0]  dmask, bmask;
    vec_t        v;

    //         we    f3      addr          sd            lat   err   ld            mask
    vecs[0]  = {1'b1, 3'b000, 32'h0000_0103, 32'hFFFF_FF80, 5'd4, 1'b0, 32'h0000_0000, 4'b0001};
    vecs[1]  = {1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd4, 1'b0, 32'hFFFF_FF80, 4'b0001};
    vecs[2]  = {1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd4, 1'b0, 32'h0000_0080, 4'b0001};
    vecs[3]  = {1'b1, 3'b000, 32'h0000_0102, 32'h1234_56AB, 5'd4, 1'b0, 32'h0000_0080, 4'b0010};
    vecs[4]  = {1'b1, 3'b000, 32'h0000_0103, 32'h0000_00CD, 5'd4, 1'b0, 32'h0000_0080, 4'b0001};
    vecs[5]  = {1'b0, 3'b101, 32'h0000_0102, 32'h0,        5'd5, 1'b0, 32'h0000_ABCD, 4'b0011};
    vecs[6]  = {1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd5, 1'b0, 32'hFFFF_ABCD, 4'b0011};
    vecs[7]  = {1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 5'd7, 1'b0, 32'hFFFF_ABCD, 4'b1111};
    vecs[8]  = {1'b0, 3'b010, 32'h0000_0200, 32'h0,        5'd7, 1'b0, 32'hDEAD_BEEF, 4'b1111};
    vecs[9]  = {1'b1, 3'b000, 32'h0000_0201, 32'h0000_0055, 5'd4, 1'b0, 32'hDEAD_BEEF, 4'b0100};
    vecs[10] = {1'b0, 3'b010, 32'h0000_0200, 32'h0,        5'd7, 1'b0, 32'hDE55_BEEF, 4'b1111};
    vecs[11] = {1'b0, 3'b001, 32'h0000_0200, 32'h0,        5'd5, 1'b0, 32'hFFFF_DE55, 4'b1100};
    vecs[12] = {1'b0, 3'b100, 32'h0000_0202, 32'h0,        5'd4, 1'b0, 32'h0000_00BE, 4'b0010};
    vecs[13] = {1'b0, 3'b010, 32'h0000_0201, 32'h0,        5'd1, 1'b1, 32'h0000_00BE, 4'b0000};
    vecs[14] = {1'b1, 3'b001, 32'h0000_0203, 32'h0,        5'd1, 1'b1, 32'h0000_00BE, 4'b0000};
    vecs[15] = {1'b0, 3'b111, 32'h0000_0000, 32'h0,        5'd1, 1'b1, 32'h0000_00BE, 4'b0000};
    vecs[16] = {1'b1, 3'b100, 32'h0000_0000, 32'h0,        5'd1, 1'b1, 32'h0000_00BE, 4'b0000};
    vecs[17] = {1'b0, 3'b011, 32'h0000_0000, 32'h0,        5'd1, 1'b1, 32'h0000_00BE, 4'b0000};
    vecs[18] = {1'b0, 3'b000, 32'h0000_0200, 32'h0,        5'd4, 1'b0, 32'hFFFF_FFDE, 4'b1000};
    vecs[19] = {1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 5'd5, 1'b0, 32'hFFFF_FFDE, 4'b0011};
    vecs[20] = {1'b0, 3'b010, 32'h0000_0200, 32'h0,        5'd7, 1'b0, 32'hDE55_1234, 4'b1111};
    vecs[21] = {1'b0, 3'b001, 32'h0000_0202, 32'h0,        5'd5, 1'b0, 32'h0000_1234, 4'b0011};
    vecs[22] = {1'b1, 3'b101, 32'h0000_0202, 32'h0,        5'd1, 1'b1, 32'h0000_1234, 4'b0000};
    vecs[23] = {1'b0, 3'b001, 32'h0000_0201, 32'h0,        5'd1, 1'b1, 32'h0000_1234, 4'b0000};

    reset = 1'b0; request = 1'b0; write_enable = 1'b0; funct3 = 3'b000;
    address = 32'h0; store_data = 32'h0; resp_hold = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      v = vecs[i];
      run_access(v.we, v.f3, v.addr, v.sd, lat, err, ld, mask, maddr, mst, bus1, rel_idle, en_cnt);
      check($sformatf("v%0d latency", i), lat, {27'h0, v.lat});
      check($sformatf("v%0d error", i), {31'h0, err}, {31'h0, v.err});
      check($sformatf("v%0d load_data", i), ld, v.ld);
      if (v.err) begin
        check($sformatf("v%0d enable_cycles", i), en_cnt, 32'd0);
      end else begin
        check($sformatf("v%0d frame_mask", i), {28'h0, mask}, {28'h0, v.mask});
        check($sformatf("v%0d mem_address", i), maddr, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d mem_state", i), {31'h0, mst}, {31'h0, v.we});
        check($sformatf("v%0d release_busz", i), {31'h0, rel_idle}, 32'h1);
        if (v.we) begin
          check($sformatf("v%0d store_bus", i), bus1, v.sd);
        end else begin
          check($sformatf("v%0d load_busz", i), {31'h0, bus_idle(bus1)}, 32'h1);
        end
      end
    end

    // Timeout: responder never completes a word load.
    resp_hold = 1'b1;
    run_access(1'b0, 3'b010, 32'h0, 32'h0, lat, err, ld, mask, maddr, mst, bus1, rel_idle, en_cnt);
    resp_hold = 1'b0;
    check("timeout latency", lat, 32'd17);
    check("timeout enable_cycles", en_cnt, 32'd16);
    check("timeout error", {31'h0, err}, 32'h1);
    check("timeout load_data", ld, 32'h0000_1234);

    // request held high: second acceptance only after the post-RELEASE idle cycle.
    @(posedge CLK); #1;
    write_enable = 1'b0; funct3 = 3'b000; address = 32'h103; request = 1'b1;
    @(posedge CLK); #1;
    dmask = 10'h0; bmask = 10'h0;
    for (int k = 1; k <= 10; k++) begin
      dmask[k-1] = access_done;
      bmask[k-1] = busy;
      if (k == 10) request = 1'b0;
      @(posedge CLK); #1;
    end
    check("b2b done_pattern", {22'h0, dmask}, 32'h108);
    check("b2b busy_pattern", {22'h0, bmask}, 32'h1EF);
    check("b2b load_data", load_data, 32'hFFFF_FFCD);

    // Reset during a word load's ACCESS phase.
    @(posedge CLK); #1;
    write_enable = 1'b0; funct3 = 3'b010; address = 32'h200; request = 1'b1;
    @(posedge CLK); #1;
    request = 1'b0;
    @(posedge CLK); #1;
    check("midrst enable_before", {31'h0, mem_enable}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("midrst");
    seen_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      seen_done = seen_done | access_done;
    end
    check("midrst no_done", {31'h0, seen_done}, 32'h0);
    reset = 1'b1;
    run_access(1'b0, 3'b000, 32'h102, 32'h0, lat, err, ld, mask, maddr, mst, bus1, rel_idle, en_cnt);
    check("postrst latency", lat, 32'd4);
    check("postrst error", {31'h0, err}, 32'h0);
    check("postrst load_data", ld, 32'hFFFF_FFAB);
    check("postrst frame_mask", {28'h0, mask}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
